// File: rtl/ioctl_sdram_reader.sv
// Serves hps_io upload byte reads from a spare SDRAM port (toggle req/ack),
// with a one-word cache so the second byte of a word needs no extra fetch.
// Ports: CLK_32M/reset_n; ioctl_upload/index/rd/addr in, ioctl_din/wait out;
// sdr_addr/req/wr_sel/din out, sdr_ack/dout in; busy high outside IDLE.
module ioctl_sdram_reader #(
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter logic [23:0] BASE_WORD    = 24'h000000,
  parameter logic [24:0] SIZE_BYTES   = 25'h0010000
) (
  input  logic        CLK_32M,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [23:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_dout,
  output logic [1:0]  sdr_wr_sel,
  output logic [15:0] sdr_din,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_RESYNC,
    S_IDLE,
    S_FETCH
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic        lane_q, lane_d;
  logic [15:0] cache_q, cache_d;
  logic [23:0] tag_q, tag_d;
  logic        cvld_q, cvld_d;
  logic        pend_q, pend_d;
  logic [24:0] paddr_q, paddr_d;
  logic        upl_q, upl_d;
  logic        drop_q, drop_d;

  logic        act;
  logic        synced;
  logic        serve;
  logic [24:0] rd_addr;
  logic [23:0] rd_word;
  logic        oor;
  logic        hit;

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESYNC;
      req_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      wait_q  <= 1'b0;
      lane_q  <= 1'b0;
      cache_q <= '0;
      tag_q   <= '0;
      cvld_q  <= 1'b0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      upl_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      lane_q  <= lane_d;
      cache_q <= cache_d;
      tag_q   <= tag_d;
      cvld_q  <= cvld_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      upl_q   <= upl_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    act = ioctl_rd & ioctl_upload
        & (ioctl_index == UPLOAD_INDEX);
    synced = (req_q == sdr_ack);
    // A read held over from RESYNC is served from its latched address.
    rd_addr = (state_q == S_RESYNC && pend_q) ? paddr_q : ioctl_addr;
    rd_word = BASE_WORD + rd_addr[24:1];
    oor = (rd_addr >= SIZE_BYTES);
    // Tag holds the SDRAM word address; the base offset is a bijection.
    hit = cvld_q & (tag_q == rd_word);
    serve = ((state_q == S_IDLE) & act)
          | ((state_q == S_RESYNC) & synced & (pend_q | act));

    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wait_d  = wait_q;
    lane_d  = lane_q;
    cache_d = cache_q;
    tag_d   = tag_q;
    cvld_d  = cvld_q;
    pend_d  = pend_q;
    paddr_d = paddr_q;
    upl_d   = ioctl_upload;
    drop_d  = drop_q;

    if (upl_q & ~ioctl_upload) begin
      cvld_d = 1'b0;
      drop_d = drop_q | (state_q == S_FETCH);
    end

    unique case (state_q)
      S_RESYNC: begin
        if (synced) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end else if (act) begin
          pend_d  = 1'b1;
          paddr_d = ioctl_addr;
          wait_d  = 1'b1;
        end
      end
      S_IDLE: ;
      S_FETCH: begin
        if (synced) begin
          // The toggle cannot be cancelled, so an aborted session
          // still waits for the ack and then drops the data.
          if (!drop_q && ioctl_upload) begin
            cache_d = sdr_dout;
            tag_d   = addr_q;
            cvld_d  = 1'b1;
            din_d   = lane_q ? sdr_dout[15:8] : sdr_dout[7:0];
          end
          wait_d  = 1'b0;
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_RESYNC;
    endcase

    if (serve) begin
      if (oor) begin
        din_d  = 8'hFF;
        wait_d = 1'b0;
      end else if (hit) begin
        din_d  = rd_addr[0] ? cache_q[15:8] : cache_q[7:0];
        wait_d = 1'b0;
      end else begin
        req_d   = ~req_q;
        addr_d  = rd_word;
        lane_d  = rd_addr[0];
        wait_d  = 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign sdr_addr   = addr_q;
  assign sdr_req    = req_q;
  assign sdr_wr_sel = 2'b00;
  assign sdr_din    = 16'h0000;
  assign busy       = (state_q != S_IDLE);

endmodule
